// File: rtl/shift_seq_32.sv
// Iterative shift/rotate unit (SLL/SRL/SRA/ROR) that moves one bit per clock for the execute stage.
// Latency: shamt+2 cycles from the accepted start to the done pulse; a new start is accepted in the done cycle.
// Backpressure: none; start is ignored while busy and the caller must wait for done.
module shift_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int SHW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_val;

    // Only the low bits of B carry the shift amount.
    logic unused_b_hi;
    assign unused_b_hi = ^B[WIDTH-1:SHW];

    always_comb begin
        step_val = acc_q;
        case (op_q)
            2'b00: step_val = {acc_q[WIDTH-2:0], 1'b0};
            2'b01: step_val = {1'b0, acc_q[WIDTH-1:1]};
            2'b10: step_val = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            2'b11: step_val = {acc_q[0], acc_q[WIDTH-1:1]};
            default: step_val = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = A;
                    cnt_d   = B[SHW-1:0];
                    op_d    = op;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Exit is tested before decrementing so cnt never wraps.
                if (cnt_q != 5'd0) begin
                    acc_d = step_val;
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    res_d   = acc_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign res  = res_q;

endmodule

// File: tb/tb_shift_seq_32.sv
// Directed bench for shift_seq_32: a vector table plus hand sequences for the multi-cycle corner cases.
module tb_shift_seq_32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] res;

    shift_seq_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op_i),
        .A     (a_i),
        .B     (b_i),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t        vecs[10];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] last_res = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called between posedges; issues start now, then scrambles the operands after the start edge.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int busy_n;
        bit held;
        lat = 0; busy_n = 0; held = 1'b1;
        op_i = o; a_i = a; b_i = b; start = 1'b1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            a_i   = ~a;
            b_i   = 32'h0;
            op_i  = ~o;
            @(negedge clk);
            if (done) lat = c;
            else begin
                if (busy) busy_n++;
                if (res !== last_res) held = 1'b0;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " res"}, res, exp_res);
        check({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        check({name, " res held until done"}, {31'h0, held}, 32'h1);
        last_res = exp_res;
    endtask

    initial begin
        int ndone;
        int first;

        vecs[0] = '{SLL, 32'h0000_0001, 32'd31,        32'h8000_0000, 33};
        vecs[1] = '{SRA, 32'h8000_00F0, 32'd4,         32'hF800_000F, 6};
        vecs[2] = '{SRL, 32'h8000_00F0, 32'd4,         32'h0800_000F, 6};
        vecs[3] = '{ROR, 32'h1234_5678, 32'd0,         32'h1234_5678, 2};
        vecs[4] = '{ROR, 32'h1234_5678, 32'd8,         32'h7812_3456, 10};
        vecs[5] = '{SLL, 32'hFFFF_FFFF, 32'h0000_0023, 32'hFFFF_FFF8, 5};
        vecs[6] = '{SRA, 32'h7FFF_FFFF, 32'd31,        32'h0000_0000, 33};
        vecs[7] = '{SRL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 33};
        vecs[8] = '{SLL, 32'h0000_00A5, 32'hFFFF_FFE0, 32'h0000_00A5, 2};
        vecs[9] = '{SRA, 32'h8000_0000, 32'd1,         32'hC000_0000, 3};

        rst_n = 1'b0; start = 1'b0; op_i = 2'b00; a_i = 32'h0; b_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset res", res, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
            if (i % 2 == 1) repeat (2) @(negedge clk);
        end

        // Start during SHIFT is ignored and operands are captured at start.
        @(negedge clk);
        op_i = SRL; a_i = 32'hF000_0000; b_i = 32'd4; start = 1'b1;
        ndone = 0; first = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            start = (c == 2);
            if (c == 2) begin a_i = 32'h0; b_i = 32'h0; end
            if (c == 3) a_i = 32'hFFFF_FFFF;
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        check("ignored start done cycle", 32'(first), 32'd6);
        check("ignored start done count", 32'(ndone), 32'd1);
        check("ignored start res", res, 32'h0F00_0000);
        last_res = 32'h0F00_0000;

        // Reset in the middle of a shift aborts it.
        @(negedge clk);
        op_i = SLL; a_i = 32'h0000_0001; b_i = 32'd10; start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            rst_n = (c != 5);
            @(negedge clk);
            if (c == 5) check("pre-reset busy", {31'h0, busy}, 32'h1);
            if (c == 6) begin
                check("mid reset busy", {31'h0, busy}, 32'h0);
                check("mid reset done", {31'h0, done}, 32'h0);
                check("mid reset res", res, 32'h0);
            end
            if (done) ndone++;
        end
        check("aborted op done count", 32'(ndone), 32'd0);
        last_res = 32'h0;

        // Back-to-back: second start issued in the done cycle of the first.
        @(negedge clk);
        run_op("b2b first", SRA, 32'h8000_00F0, 32'd4, 32'hF800_000F, 6);
        run_op("b2b second", ROR, 32'h0000_0003, 32'd1, 32'h8000_0001, 3);
        @(negedge clk);
        check("done pulse width", {31'h0, done}, 32'h0);
        check("idle after done busy", {31'h0, busy}, 32'h0);
        check("res held in idle", res, 32'h8000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
